itch_byte_parser: RTL and testbench

Byte-stream message parser between the RX pipeline register (RX→Parser stage) and the Parser→Logic pipeline register.
- Consumes one byte per cycle through a valid/ready handshake.
- Frames fixed-length, big-endian market messages.
- Presents each complete decoded message as a single parallel word (type, order_id, price, volume) with its own valid/ready handshake.
- Drops unknown type bytes and counts them as errors, which resynchronises the stream.

---
 rtl/itch_pkg.sv | 44 ++++
 rtl/itch_byte_parser.sv | 174 +++++++++++++++++
 tb/tb_itch_byte_parser.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/itch_pkg.sv
// -----------------------------------------------------------------------------
// itch_pkg
// Shared definitions for the ITCH byte-stream parser.
//   - Message type byte constants and payload lengths (bytes after the type).
//   - Parser state enum.
//   - Decoded message struct.
//   - msg_payload_len(): payload length for a type byte, 0 for unknown types.
// -----------------------------------------------------------------------------
package itch_pkg;

    localparam logic [7:0] MSG_ADD  = 8'h41;
    localparam logic [7:0] MSG_DEL  = 8'h44;
    localparam logic [7:0] MSG_EXEC = 8'h45;

    localparam logic [4:0] LEN_ADD  = 5'd16;
    localparam logic [4:0] LEN_DEL  = 5'd8;
    localparam logic [4:0] LEN_EXEC = 5'd12;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        EMIT
    } state_t;

    typedef struct packed {
        logic [7:0]  msg_type;
        logic [63:0] order_id;
        logic [31:0] price;
        logic [31:0] volume;
    } msg_t;

    // Zero doubles as the "unknown type" marker; no real message is empty.
    function automatic logic [4:0] msg_payload_len(input logic [7:0] msg_type);
        logic [4:0] len;
        case (msg_type)
            MSG_ADD:  len = LEN_ADD;
            MSG_DEL:  len = LEN_DEL;
            MSG_EXEC: len = LEN_EXEC;
            default:  len = 5'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/itch_byte_parser.sv
// -----------------------------------------------------------------------------
// itch_byte_parser
// Frames a byte stream of fixed-length big-endian ITCH messages (ADD, DEL,
// EXEC) and presents each complete message as one parallel word.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/in_valid/in_ready
//                          byte stream input, one byte per cycle
//   out_type/out_order_id/out_price/out_volume
//                          decoded message fields (price/volume 0 when absent)
//   out_valid/out_ready    decoded message handshake
//   msg_count, err_count   saturating counters: messages emitted, errors
//                          (unknown type bytes plus timeout aborts)
//   busy                   high while a message payload is being collected
//
// Build option
//   ITCH_PARSER_TIMEOUT_EN  when defined, a partial message idle for
//                           TIMEOUT_CYCLES cycles is discarded and counted as
//                           an error. When undefined, the parser waits forever.
// -----------------------------------------------------------------------------
module itch_byte_parser
    import itch_pkg::*;
#(
    parameter int          CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_type,
    output logic [63:0]      out_order_id,
    output logic [31:0]      out_price,
    output logic [31:0]      out_volume,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    msg_t       msg_q, msg_d;
    logic       accept;
    logic       msg_done;
    logic       type_err;
    logic       abort;
    logic [4:0] cur_len;
    logic [4:0] new_len;

    assign in_ready = (state_q == IDLE) || (state_q == PAYLOAD) ||
                      ((state_q == EMIT) && out_ready);
    assign accept   = in_valid && in_ready;
    assign cur_len  = msg_payload_len(msg_q.msg_type);
    assign new_len  = msg_payload_len(in_data);

`ifdef ITCH_PARSER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_q;

    // Counts consecutive PAYLOAD cycles without an accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if ((state_q != PAYLOAD) || accept) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + TO_W'(1);
        end
    end

    // Fires on the cycle in which the idle count would reach TIMEOUT_CYCLES.
    assign abort = (state_q == PAYLOAD) && !accept &&
                   (idle_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        msg_d    = msg_q;
        msg_done = 1'b0;
        type_err = 1'b0;

        unique case (state_q)
            IDLE: begin
            end
            PAYLOAD: begin
                if (accept) begin
                    // Index 1-8 is always order_id; 9-12 is price only for
                    // ADD, otherwise everything past order_id is volume.
                    if (idx_q <= 5'd8) begin
                        msg_d.order_id = {msg_q.order_id[55:0], in_data};
                    end else if ((msg_q.msg_type == MSG_ADD) && (idx_q <= 5'd12)) begin
                        msg_d.price = {msg_q.price[23:0], in_data};
                    end else begin
                        msg_d.volume = {msg_q.volume[23:0], in_data};
                    end
                    if (idx_q == cur_len) begin
                        state_d = EMIT;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    msg_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A byte accepted outside PAYLOAD is always a type byte; this covers
        // IDLE and the handshake cycle of EMIT for zero-bubble streaming.
        if (accept && (state_q != PAYLOAD)) begin
            if (new_len != 5'd0) begin
                msg_d.msg_type = in_data;
                msg_d.order_id = '0;
                msg_d.price    = '0;
                msg_d.volume   = '0;
                idx_d          = 5'd1;
                state_d        = PAYLOAD;
            end else begin
                type_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            msg_q     <= '0;
            msg_count <= '0;
            err_count <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            msg_q   <= msg_d;
            if (msg_done) begin
                msg_count <= sat_inc(msg_count);
            end
            if (type_err || abort) begin
                err_count <= sat_inc(err_count);
            end
        end
    end

    assign out_valid    = (state_q == EMIT);
    assign busy         = (state_q == PAYLOAD);
    assign out_type     = msg_q.msg_type;
    assign out_order_id = msg_q.order_id;
    assign out_price    = msg_q.price;
    assign out_volume   = msg_q.volume;

endmodule

// File: tb/tb_itch_byte_parser.sv
// -----------------------------------------------------------------------------
// tb_itch_byte_parser
// Directed stimulus for itch_byte_parser. Expected messages are queued when
// issued; a monitor compares each completed output handshake against the
// queue head. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_itch_byte_parser;
    import itch_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       out_type;
    logic [63:0]      out_order_id;
    logic [31:0]      out_price;
    logic [31:0]      out_volume;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] msg_count;
    logic [CNT_W-1:0] err_count;
    logic             busy;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    msg_t exp_q[$];

    itch_byte_parser #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_type     (out_type),
        .out_order_id (out_order_id),
        .out_price    (out_price),
        .out_volume   (out_volume),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .msg_count    (msg_count),
        .err_count    (err_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one comparison per completed output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            msg_t got;
            msg_t exp;
            got = '{out_type, out_order_id, out_price, out_volume};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_msg: got type=%0h id=%0h price=%0h vol=%0h expected none",
                         got.msg_type, got.order_id, got.price, got.volume);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fails++;
                    $display("FAIL msg_fields: got type=%0h id=%0h price=%0h vol=%0h expected type=%0h id=%0h price=%0h vol=%0h",
                             got.msg_type, got.order_id, got.price, got.volume,
                             exp.msg_type, exp.order_id, exp.price, exp.volume);
                end
            end
        end
    end

    // Drives one byte and returns 1 time unit after the edge that accepted it.
    task automatic send(input logic [7:0] b);
        int w;
        w        = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic [7:0] t, input logic [63:0] id,
                            input logic [31:0] p, input logic [31:0] v);
        logic [63:0] sid;
        logic [31:0] sp;
        logic [31:0] sv;
        sid = id;
        sp  = p;
        sv  = v;
        send(t);
        for (int i = 0; i < 8; i++) begin
            send(sid[63:56]);
            sid = sid << 8;
        end
        if (t == MSG_ADD) begin
            for (int i = 0; i < 4; i++) begin
                send(sp[31:24]);
                sp = sp << 8;
            end
        end
        if (t == MSG_ADD || t == MSG_EXEC) begin
            for (int i = 0; i < 4; i++) begin
                send(sv[31:24]);
                sv = sv << 8;
            end
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_msg_count", msg_count, 0);
        check("rst_err_count", err_count, 0);
        check("rst_fields", {out_type, out_order_id, out_price, out_volume}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;

        // 1: single ADD, 1-cycle latency to out_valid
        out_ready = 1'b1;
        do_reset();
        exp_q.push_back('{8'h41, 64'h0000000000001234, 32'h000186A0, 32'h00000064});
        send_msg(8'h41, 64'h0000000000001234, 32'h000186A0, 32'h00000064);
        in_valid = 1'b0;
        @(negedge clk);
        check("add_out_valid_latency", out_valid, 1);
        @(posedge clk);
        #1;
        check("add_msg_count", msg_count, 1);
        check("add_out_valid_drop", out_valid, 0);

        // 2: DEL held by back-pressure for 5 cycles
        out_ready = 1'b0;
        do_reset();
        exp_q.push_back('{8'h44, 64'h0102030405060708, 32'h0, 32'h0});
        send_msg(8'h44, 64'h0102030405060708, 32'h0, 32'h0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("del_stall_valid", out_valid, 1);
            check("del_stall_in_ready", in_ready, 0);
            check("del_stall_id", out_order_id, 64'h0102030405060708);
            @(posedge clk);
            #1;
        end
        check("del_msg_count_held", msg_count, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("del_msg_count", msg_count, 1);
        check("del_out_valid_drop", out_valid, 0);

        // 3: unknown byte then EXEC
        do_reset();
        send(8'h7A);
        in_valid = 1'b0;
        check("unknown_err_count", err_count, 1);
        check("unknown_busy", busy, 0);
        exp_q.push_back('{8'h45, 64'h000000000000000A, 32'h0, 32'h0000000F});
        send_msg(8'h45, 64'h000000000000000A, 32'h0, 32'h0000000F);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("exec_msg_count", msg_count, 1);
        check("exec_err_count", err_count, 1);

        // 4: back-to-back ADDs with no bubble
        do_reset();
        exp_q.push_back('{8'h41, 64'h1122334455667788, 32'h99AABBCC, 32'hDDEEFF00});
        exp_q.push_back('{8'h41, 64'h8000000000000001, 32'hFFFFFFFF, 32'h00000001});
        t0 = cyc;
        send_msg(8'h41, 64'h1122334455667788, 32'h99AABBCC, 32'hDDEEFF00);
        send_msg(8'h41, 64'h8000000000000001, 32'hFFFFFFFF, 32'h00000001);
        in_valid = 1'b0;
        check("b2b_cycles", cyc - t0, 34);
        @(posedge clk);
        #1;
        check("b2b_msg_count", msg_count, 2);

        // 5: reset mid-payload, then a fresh DEL
        do_reset();
        send(8'h41);
        for (int i = 0; i < 4; i++) send(8'h55);
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        do_reset();
        exp_q.push_back('{8'h44, 64'hDEADBEEF00112233, 32'h0, 32'h0});
        send_msg(8'h44, 64'hDEADBEEF00112233, 32'h0, 32'h0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_msg_count", msg_count, 1);
        check("post_rst_err_count", err_count, 0);

        // 6: stall inside a partial ADD
        do_reset();
        send(8'h41);
        send(8'h00);
        send(8'h00);
        in_valid = 1'b0;
`ifdef ITCH_PARSER_TIMEOUT_EN
        repeat (7) @(posedge clk);
        #1;
        check("to_busy_before", busy, 1);
        @(posedge clk);
        #1;
        check("to_busy_after", busy, 0);
        check("to_err_count", err_count, 1);
        exp_q.push_back('{8'h41, 64'h0000000000000077, 32'h00000010, 32'h00000020});
        send_msg(8'h41, 64'h0000000000000077, 32'h00000010, 32'h00000020);
`else
        repeat (40) @(posedge clk);
        #1;
        check("wait_busy", busy, 1);
        check("wait_err_count", err_count, 0);
        // Remaining 6 order_id bytes, then price and volume.
        for (int i = 0; i < 5; i++) send(8'h00);
        send(8'h77);
        for (int i = 0; i < 3; i++) send(8'h00);
        send(8'h10);
        for (int i = 0; i < 3; i++) send(8'h00);
        send(8'h20);
        exp_q.push_back('{8'h41, 64'h0000000000000077, 32'h00000010, 32'h00000020});
`endif
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("final_msg_count", msg_count, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
